// File: rtl/gcd_batch_engine_pkg.sv
// Shared types and constants for the batch GCD accelerator.
package gcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CNT,
    S_RD_A,
    S_RD_B,
    S_CALC,
    S_WR,
    S_FIN
  } state_e;

  localparam int GCD_SUB     = 0;
  localparam int GCD_BIN     = 1;
  localparam int WORD_STRIDE = 4;

endpackage

// File: rtl/gcd_batch_engine_if.sv
// Control and data-memory port bundle of the batch GCD accelerator.
interface gcd_batch_engine_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  pairs_done;
  logic [ADDR_W-1:0] data_addr;
  logic [WIDTH-1:0]  data_out;
  logic [WIDTH-1:0]  data_in;
  logic              mem_read;
  logic              mem_write;

  modport master (
    input  start, src_base, dst_base, data_in,
    output busy, done, pairs_done, data_addr, data_out, mem_read, mem_write
  );

  modport slave (
    output start, src_base, dst_base, data_in,
    input  busy, done, pairs_done, data_addr, data_out, mem_read, mem_write
  );
endinterface

// File: rtl/gcd_batch_engine_core.sv
// One-step-per-cycle GCD datapath: subtractive or binary (Stein) reduction.
module gcd_core
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MODE  = GCD_SUB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             res_valid
);
  localparam int KW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [KW-1:0]    k_q;

  // a|b covers both the zero-operand and equal-operand terminations
  always_comb begin
    res_valid = (a_q == '0) || (b_q == '0) || (a_q == b_q);
    result    = (a_q | b_q) << k_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      k_q <= '0;
    end else if (load) begin
      a_q <= a;
      b_q <= b;
      k_q <= '0;
    end else if (!res_valid) begin
      if (MODE == GCD_BIN && !a_q[0] && !b_q[0]) begin
        a_q <= a_q >> 1;
        b_q <= b_q >> 1;
        k_q <= k_q + KW'(1);
      end else if (MODE == GCD_BIN && !a_q[0]) begin
        a_q <= a_q >> 1;
      end else if (MODE == GCD_BIN && !b_q[0]) begin
        b_q <= b_q >> 1;
      end else if (a_q > b_q) begin
        a_q <= a_q - b_q;
      end else begin
        b_q <= b_q - a_q;
      end
    end
  end
endmodule

// File: rtl/gcd_batch_engine.sv
// Batch GCD engine: reads count and operand pairs from memory, writes GCDs back.
module gcd_batch_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32,
  parameter int MODE   = GCD_SUB
) (
  input logic              clk,
  input logic              rst,
  gcd_batch_engine_if.master bus
);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_STRIDE);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  cnt_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  pairs_q;
  logic [WIDTH-1:0]  dout_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_q;
  logic              wr_q;

  logic              core_load;
  logic              core_valid;
  logic [WIDTH-1:0]  core_res;

  assign core_load = (state_q == S_RD_B);

  gcd_core #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (core_load),
    .a         (a_q),
    .b         (bus.data_in),
    .result    (core_res),
    .res_valid (core_valid)
  );

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pairs_done = pairs_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_out   = dout_q;
  assign bus.mem_read   = rd_q;
  assign bus.mem_write  = wr_q;

  // Strobes and address are registered one state ahead so each state drives its own access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      pairs_q <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      dout_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            dst_q   <= bus.dst_base;
            ptr_q   <= bus.src_base + STRIDE;
            pairs_q <= '0;
            busy_q  <= 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= bus.src_base;
            state_q <= S_RD_CNT;
          end
        end
        S_RD_CNT: begin
          cnt_q <= bus.data_in;
          if (bus.data_in == '0) begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            rd_q    <= 1'b1;
            addr_q  <= ptr_q;
            ptr_q   <= ptr_q + STRIDE;
            state_q <= S_RD_A;
          end
        end
        S_RD_A: begin
          a_q     <= bus.data_in;
          rd_q    <= 1'b1;
          addr_q  <= ptr_q;
          ptr_q   <= ptr_q + STRIDE;
          state_q <= S_RD_B;
        end
        S_RD_B: state_q <= S_CALC;
        S_CALC: begin
          if (core_valid) begin
            wr_q    <= 1'b1;
            addr_q  <= dst_q + ADDR_W'(pairs_q) * STRIDE;
            dout_q  <= core_res;
            state_q <= S_WR;
          end
        end
        S_WR: begin
          pairs_q <= pairs_q + WIDTH'(1);
          if (pairs_q + WIDTH'(1) == cnt_q) begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            rd_q    <= 1'b1;
            addr_q  <= ptr_q;
            ptr_q   <= ptr_q + STRIDE;
            state_q <= S_RD_A;
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_batch_engine.sv
// Bench for gcd_batch_engine: three configurations run the same batches against a Euclid model.
module tb_gcd_batch_engine;
  localparam int NI = 3;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        ld    = 1'b0;
  logic [31:0] src   = '0;
  logic [31:0] dst   = '0;

  logic [31:0] img [64];
  logic [31:0] mem [NI][64];

  logic [NI-1:0] busy_w, done_w, rd_w, wr_w;
  logic [31:0]   addr_w [NI];
  logic [31:0]   dout_w [NI];
  logic [31:0]   pd_w   [NI];

  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned done_cnt [NI];
  int unsigned wr_cnt   [NI];
  int unsigned done_at  [NI];
  int unsigned lat      [NI];
  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] pa [5];
  logic [31:0] pb [5];

  always #5 clk = ~clk;

  // inst 0: 32-bit subtractive, inst 1: 32-bit binary, inst 2: 16-bit binary
  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int W = (gi == 2) ? 16 : 32;
    localparam int M = (gi == 0) ? 0 : 1;
    logic [31:0] rdw;

    gcd_batch_engine_if #(.WIDTH(W), .ADDR_W(32)) bus ();

    gcd_batch_engine #(.WIDTH(W), .ADDR_W(32), .MODE(M)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
    );

    assign bus.start    = start;
    assign bus.src_base = src;
    assign bus.dst_base = dst;
    assign rdw          = mem[gi][bus.data_addr[7:2]];
    assign bus.data_in  = bus.mem_read ? rdw[W-1:0] : '0;
    assign busy_w[gi]   = bus.busy;
    assign done_w[gi]   = bus.done;
    assign rd_w[gi]     = bus.mem_read;
    assign wr_w[gi]     = bus.mem_write;
    assign addr_w[gi]   = bus.data_addr;
    assign dout_w[gi]   = 32'(bus.data_out);
    assign pd_w[gi]     = 32'(bus.pairs_done);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (ld) begin
        for (int w = 0; w < 64; w++) mem[i][w] <= img[w];
      end else if (wr_w[i]) begin
        mem[i][addr_w[i][7:2]] <= dout_w[i];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (done_w[i]) begin
        done_cnt[i] = done_cnt[i] + 1;
        done_at[i]  = cyc;
      end
      if (wr_w[i]) wr_cnt[i] = wr_cnt[i] + 1;
    end
  end

  function automatic int unsigned wid(input int unsigned i);
    return (i == 2) ? 16 : 32;
  endfunction

  function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [31:0] m, x, y, t;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    x = a & m;
    y = b & m;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic launch(input int unsigned n);
    for (int w = 0; w < 64; w++) img[w] = SENT;
    img[0] = n;
    for (int j = 0; j < int'(n); j++) begin
      img[1 + 2 * j] = pa[j];
      img[2 + 2 * j] = pb[j];
    end
    @(negedge clk) ld = 1'b1;
    @(negedge clk) ld = 1'b0;
    src   = 32'd0;
    dst   = 32'd44;
    start = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_batch(input int unsigned n, input bit poke, input int unsigned budget);
    int unsigned d0 [NI];
    int unsigned w0 [NI];
    int unsigned k;
    bit          all;
    for (int i = 0; i < NI; i++) begin
      d0[i] = done_cnt[i];
      w0[i] = wr_cnt[i];
    end
    launch(n);
    all = 1'b0;
    k   = 0;
    while (!all && k < budget) begin
      @(negedge clk);
      k++;
      start = poke && (k == 1);
      all = 1'b1;
      for (int i = 0; i < NI; i++) if (done_cnt[i] == d0[i]) all = 1'b0;
    end
    start = 1'b0;
    chk("timeout", 32'(all), 32'd1);
    repeat (6) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      lat[i] = done_at[i] - start_cyc + 1;
      chk($sformatf("done_pulses%0d", i), done_cnt[i] - d0[i], 32'd1);
      chk($sformatf("writes%0d", i), wr_cnt[i] - w0[i], n);
      chk($sformatf("pairs_done%0d", i), pd_w[i], n);
      chk($sformatf("busy_idle%0d", i), 32'(busy_w[i]), 32'd0);
      for (int j = 0; j < int'(n); j++)
        chk($sformatf("res%0d_%0d", i, j), mem[i][11 + j], gcd_ref(pa[j], pb[j], wid(i)));
      if (n < 5) chk($sformatf("no_extra%0d", i), mem[i][11 + n], SENT);
    end
  endtask

  initial begin
    bit          found;
    int unsigned k;
    int unsigned w0 [NI];

    for (int w = 0; w < 64; w++) img[w] = SENT;
    @(negedge clk) ld = 1'b1;
    @(negedge clk) ld = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_strobes%0d", i),
          32'({busy_w[i], done_w[i], rd_w[i], wr_w[i]}), 32'd0);
      chk($sformatf("rst_addr%0d", i), addr_w[i], 32'd0);
      chk($sformatf("rst_dout%0d", i), dout_w[i], 32'd0);
      chk($sformatf("rst_pd%0d", i), pd_w[i], 32'd0);
    end
    rst = 1'b0;

    pa = '{48, 101, 128, 27, 56};
    pb = '{36, 13, 32, 9, 42};
    run_batch(5, 1'b1, 3000);

    pa[0] = 48; pb[0] = 36;
    run_batch(1, 1'b1, 200);
    chk("lat_sub", lat[0], 32'd9);
    chk("lat_bin", lat[1], 32'd12);
    chk("lat_bin16", lat[2], 32'd12);

    pa[0] = 0; pb[0] = 20;
    pa[1] = 20; pb[1] = 0;
    pa[2] = 0; pb[2] = 0;
    run_batch(3, 1'b1, 200);
    for (int i = 0; i < NI; i++) chk($sformatf("lat_zero%0d", i), lat[i], 32'd14);

    run_batch(0, 1'b0, 100);
    for (int i = 0; i < NI; i++) chk($sformatf("lat_cnt0_%0d", i), lat[i], 32'd2);

    pa[0] = 32'hFFFE; pb[0] = 32'h8000;
    run_batch(1, 1'b1, 20000);

    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 5; j++) begin
        logic [31:0] g;
        g = $urandom_range(1, 1000);
        pa[j] = g * $urandom_range(0, 60);
        pb[j] = g * $urandom_range(0, 60);
      end
      run_batch(5, 1'b1, 3000);
    end

    pa[0] = 0; pb[0] = 5;
    pa[1] = 1000; pb[1] = 1;
    launch(2);
    found = 1'b0;
    k = 0;
    while (!found && k < 200) begin
      @(negedge clk);
      k++;
      found = (pd_w[0] == 32'd1) && busy_w[0] && !rd_w[0] && !wr_w[0];
    end
    chk("rst_reach_calc", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("mid_rst_strobes%0d", i),
          32'({busy_w[i], done_w[i], rd_w[i], wr_w[i]}), 32'd0);
      chk($sformatf("mid_rst_addr%0d", i), addr_w[i], 32'd0);
      chk($sformatf("mid_rst_dout%0d", i), dout_w[i], 32'd0);
      chk($sformatf("mid_rst_pd%0d", i), pd_w[i], 32'd0);
      w0[i] = wr_cnt[i];
    end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("post_rst_writes%0d", i), wr_cnt[i] - w0[i], 32'd0);
      chk($sformatf("pair1_kept%0d", i), mem[i][11], 32'd5);
      chk($sformatf("pair2_untouched%0d", i), mem[i][12], SENT);
    end

    pa[0] = 48; pb[0] = 36;
    pa[1] = 81; pb[1] = 27;
    run_batch(2, 1'b1, 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
